int_to_int_pipe: RTL
====================

// Module: int_to_int_pipe
// PURPOSE
//  Pipelined, multi-lane integer-to-integer format converter for the SMC datapath.
//  Converts between signed/unsigned INT8, INT16 and INT32 with saturation, on LANES
//  32-bit words per beat, behind a valid/ready handshake.
//  Per-lane saturation flags plus a sticky saturating event counter feed status/CSR.
// PARAMETERS
//  LANES        4   number of 32-bit words per beat
//  PIPE_STAGES  2   register stages, input to output (legal: 1..4)
//  SAT_EN       1   1 = saturate on overflow; 0 = truncate/wrap (flags still reported)
//  CNT_W        16  width of the saturation event counter
// PORTS
//  clk          in   1          clock; all state updates on the rising edge
//  rst          in   1          asynchronous, active-high reset
//  in_vld       in   1          input beat valid
//  in_rdy       out  1          input beat accepted when in_vld & in_rdy
//  src_prec     in   2          source element width: 00=8, 01=16, 10=32 (11 illegal, treated as 10)
//  dst_prec     in   2          destination element width; same encoding as src_prec
//  src_signed   in   1          1 = source elements are signed
//  dst_signed   in   1          1 = destination elements are signed
//  src_pos      in   2          source element index, used only when widths differ
//  dst_pos      in   2          destination element index, used only when widths differ
//  in_data      in   32*LANES   word i = in_data[32*i+:32]
//  out_vld      out  1          output beat valid
//  out_rdy      in   1          downstream ready
//  out_data     out  32*LANES   converted words
//  out_sat      out  LANES      bit i set if any element of word i was clamped/overflowed
//  cnt_clr      in   1          synchronous clear of sat_cnt (highest priority)
//  sat_cnt      out  CNT_W      count of accepted output beats with |out_sat; sticks at all-ones
// BEHAVIOUR
//  Reset: out_vld=0, out_data=0, out_sat=0, sat_cnt=0, all pipe valids=0.
//   Reset mid-operation drops in-flight beats; nothing is replayed.
//  Config fields are sampled with each accepted beat and travel with it. Modes may change per beat.
//  Same width (src_prec==dst_prec):
//   - Every element of every word is converted in place: 4x8, 2x16 or 1x32 per word.
//   - src_pos and dst_pos are ignored.
//  Different widths:
//   - Exactly one element per word is converted.
//   - Source element = index src_pos mod (32/src_w).
//   - Result is written at destination index dst_pos mod (32/dst_w).
//   - All other destination bits are 0.
//  Conversion, SAT_EN=1:
//   - s->s: clamp to [-2^(d-1), 2^(d-1)-1].
//   - s->u: negative -> 0; above max -> 2^d-1.
//   - u->s: above 2^(d-1)-1 -> 2^(d-1)-1.
//   - u->u: above 2^d-1 -> 2^d-1.
//   - Widening is sign-extended (s->s) or zero-extended otherwise.
//  Conversion, SAT_EN=0: result is the low d bits of the sign/zero-extended source.
//  Flag: out_sat bit set whenever the value is out of destination range, for either SAT_EN value.
//  Pipeline:
//   - PIPE_STAGES stages, each a valid+data register.
//   - Stage k loads when it is empty or stage k+1 loads (out_rdy at the last stage).
//   - in_rdy = stage-0 load condition. This gives full throughput, no bubbles.
//   - Latency is PIPE_STAGES cycles from acceptance to out_vld when out_rdy=1.
//  Stall: while out_vld & !out_rdy, out_data and out_sat hold stable and in_rdy drops once all stages are full.
//  sat_cnt:
//   - Increments on out_vld & out_rdy & |out_sat.
//   - Saturates at 2^CNT_W-1.
//   - cnt_clr in the same cycle as an increment: result is 0.
// TESTING
//  16->16 s->u, in=0x8001_7FFF, SAT_EN=1 -> out 0x0000_7FFF, out_sat[0]=1, out ready after PIPE_STAGES cycles.
//  32->8 s->s, in=0xFFFF_FF00, dst_pos=2 -> out 0x0080_0000, sat=1; repeat with in=0x0000_0012 -> 0x0012_0000, sat=0.
//  8->32 s->s, in=0x0080_0000, src_pos=2 -> out 0xFFFF_FF80, sat=0; same beat u->s -> 0x0000_0080.
//  Back-to-back beats, out_rdy low for 5 cycles, then high -> no loss/duplication, order kept, in_rdy low when full.
//  SAT_EN=0, 32->16 u->u, in=0x0001_2345 -> out 0x0000_2345, sat=1; sat_cnt increments; at all-ones it holds; cnt_clr -> 0.
//  Assert rst with 2 beats in flight -> out_vld=0 immediately; after release the next beat emerges alone with correct data.

Source files
------------

// File: rtl/int_to_int_pipe.sv
// rtl/int_to_int_pipe.sv - pipelined multi-lane saturating integer format converter
module int_to_int_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter bit SAT_EN      = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [1:0]            src_prec,
  input  logic [1:0]            dst_prec,
  input  logic                  src_signed,
  input  logic                  dst_signed,
  input  logic [1:0]            src_pos,
  input  logic [1:0]            dst_pos,
  input  logic [32*LANES-1:0]   in_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [32*LANES-1:0]   out_data,
  output logic [LANES-1:0]      out_sat,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      sat_cnt
);

  // Widen one source element to a 34-bit signed value that holds any 32-bit signed or unsigned number.
  function automatic logic signed [33:0] ext(input logic [31:0] e, input logic [1:0] p, input logic sg);
    case (p)
      2'b00:   ext = sg ? {{26{e[7]}}, e[7:0]}   : {26'b0, e[7:0]};
      2'b01:   ext = sg ? {{18{e[15]}}, e[15:0]} : {18'b0, e[15:0]};
      default: ext = sg ? {{2{e[31]}}, e}        : {2'b0, e};
    endcase
  endfunction

  // Range-check against the destination format; returns {out_of_range, result in low d bits}.
  function automatic logic [32:0] conv_elem(input logic signed [33:0] v, input logic [1:0] p, input logic sg);
    logic signed [33:0] mn, mx;
    logic [31:0]        mask, r;
    logic               sat;
    case (p)
      2'b00: begin
        mask = 32'h0000_00FF;
        mn   = sg ? -34'sd128 : 34'sd0;
        mx   = sg ? 34'sd127  : 34'sd255;
      end
      2'b01: begin
        mask = 32'h0000_FFFF;
        mn   = sg ? -34'sd32768 : 34'sd0;
        mx   = sg ? 34'sd32767  : 34'sd65535;
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        mn   = sg ? -34'sd2147483648 : 34'sd0;
        mx   = sg ? 34'sd2147483647  : 34'sd4294967295;
      end
    endcase
    sat = (v < mn) || (v > mx);
    if (SAT_EN && sat) r = (v < mn) ? mn[31:0] : mx[31:0];
    else               r = v[31:0];
    return {sat, r & mask};
  endfunction

  // Convert one 32-bit word; returns {any element out of range, converted word}.
  function automatic logic [32:0] conv_word(input logic [31:0] w, input logic [1:0] sp, input logic [1:0] dp,
                                            input logic ss, input logic ds,
                                            input logic [1:0] spos, input logic [1:0] dpos);
    logic [1:0]  spn, dpn;
    logic [31:0] res, se;
    logic [32:0] e;
    logic        sat;
    spn = (sp == 2'b11) ? 2'b10 : sp;
    dpn = (dp == 2'b11) ? 2'b10 : dp;
    res = '0;
    sat = 1'b0;
    se  = '0;
    e   = '0;
    if (spn == dpn) begin
      case (spn)
        2'b00: for (int k = 0; k < 4; k++) begin
          e = conv_elem(ext({24'b0, w[8*k+:8]}, 2'b00, ss), 2'b00, ds);
          res[8*k+:8] = e[7:0];
          sat = sat | e[32];
        end
        2'b01: for (int k = 0; k < 2; k++) begin
          e = conv_elem(ext({16'b0, w[16*k+:16]}, 2'b01, ss), 2'b01, ds);
          res[16*k+:16] = e[15:0];
          sat = sat | e[32];
        end
        default: begin
          e   = conv_elem(ext(w, 2'b10, ss), 2'b10, ds);
          res = e[31:0];
          sat = e[32];
        end
      endcase
    end else begin
      case (spn)
        2'b00:   se = {24'b0, w[{spos, 3'b000}+:8]};
        2'b01:   se = {16'b0, w[{spos[0], 4'b0000}+:16]};
        default: se = w;
      endcase
      e = conv_elem(ext(se, spn, ss), dpn, ds);
      case (dpn)
        2'b00:   res[{dpos, 3'b000}+:8]     = e[7:0];
        2'b01:   res[{dpos[0], 4'b0000}+:16] = e[15:0];
        default: res = e[31:0];
      endcase
      sat = e[32];
    end
    return {sat, res};
  endfunction

  logic [32*LANES-1:0] w_cdata;
  logic [LANES-1:0]    w_csat;
  logic [PIPE_STAGES-1:0] w_ld;
  logic [PIPE_STAGES-1:0] r_vld;
  logic [32*LANES-1:0] r_data [PIPE_STAGES];
  logic [LANES-1:0]    r_sat  [PIPE_STAGES];
  logic [CNT_W-1:0]    r_cnt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [32:0] w_res;
    assign w_res = conv_word(in_data[32*i+:32], src_prec, dst_prec, src_signed, dst_signed, src_pos, dst_pos);
    assign w_cdata[32*i+:32] = w_res[31:0];
    assign w_csat[i]         = w_res[32];
  end

  // A stage may load if it or any later stage has room, or the output is being drained.
  always_comb begin
    logic acc;
    acc  = out_rdy;
    w_ld = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      acc     = acc | ~r_vld[k];
      w_ld[k] = acc;
    end
  end

  // Pipeline stage registers: conversion result enters stage 0 and advances as stages free up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_data[k] <= '0;
        r_sat[k]  <= '0;
      end
    end else begin
      if (w_ld[0]) begin
        r_vld[0] <= in_vld;
        if (in_vld) begin
          r_data[0] <= w_cdata;
          r_sat[0]  <= w_csat;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (w_ld[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_data[k] <= r_data[k-1];
            r_sat[k]  <= r_sat[k-1];
          end
        end
      end
    end
  end

  // Saturating count of delivered beats that carried any out-of-range flag; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (cnt_clr)
      r_cnt <= '0;
    else if (out_vld && out_rdy && (|out_sat) && (r_cnt != {CNT_W{1'b1}}))
      r_cnt <= r_cnt + 1'b1;
  end

  assign in_rdy   = w_ld[0];
  assign out_vld  = r_vld[PIPE_STAGES-1];
  assign out_data = r_data[PIPE_STAGES-1];
  assign out_sat  = r_sat[PIPE_STAGES-1];
  assign sat_cnt  = r_cnt;

endmodule
